fb_line_buffer: RTL and testbench
=================================

Name: fb_line_buffer

Overview:
- Downstream consumer of the GPU's framebuffer write port (write-enable, 8-bit data, 8-bit address).
- Collects one 160-pixel scanline per bank: 40 bytes, 2 bpp, 4 pixels per byte, into a two-bank ping-pong line store.
- Streams each completed line out as 2-bit pixels over a valid/ready handshake to the LCD/video driver.
- Reports line/frame boundaries and sticky overflow.

Parameters:
- LINE_BYTES, 40, bytes per scanline; byte address LINE_BYTES-1 marks end of line.
- LINES_PER_FRAME, 144, visible lines per frame; sets the line counter wrap point.

Ports:
- iClock  in  1  system clock
- iReset  in  1  synchronous, active-high reset
- iFrameBufferWe  in  1  write strobe from GPU
- iFrameBufferData  in  8  four packed pixels; pixel 0 = bits[7:6], pixel 3 = bits[1:0]
- iFrameBufferAddr  in  8  byte index within current line
- oPixel  out  2  pixel shade code
- oPixelValid  out  1  oPixel valid
- iPixelReady  in  1  consumer accepts oPixel this cycle
- oLineDone  out  1  one-cycle pulse on handshake of the last pixel of a line
- oFrameDone  out  1  one-cycle pulse, coincident with oLineDone, on the last line of a frame
- oLineCount  out  8  index of the line currently or next streamed, 0..LINES_PER_FRAME-1
- oOverflow  out  1  sticky: a write hit a full bank

Behaviour:
Interface:
- One clock, iClock.
- Reset iReset is synchronous and active-high.

Reset values:
- oPixelValid=0, oPixel=0, oLineDone=0, oFrameDone=0, oLineCount=0, oOverflow=0.
- Internal: wbank=0, rbank=0, bank_full=2'b00, byte/pixel counters=0, FSM=IDLE.
- Line-store contents are not reset.
- Reset mid-stream abandons the line in progress; both banks become empty.

Write side (evaluated each cycle with iFrameBufferWe=1):
- addr >= LINE_BYTES: ignored, no state change.
- bank_full[wbank]=1 (value at cycle start): write dropped, oOverflow<=1, wbank unchanged.
- Otherwise: mem[wbank][addr]<=data.
- If addr==LINE_BYTES-1: bank_full[wbank]<=1 and wbank toggles on the next cycle.
- Byte order within a line is not checked; only the last-address write closes the line.

Read FSM:
- IDLE:
  - If bank_full[rbank]: go to STREAM with byte=0, pix=0, oPixelValid<=1 on the next cycle.
  - First pixel appears 1 cycle after the bank becomes full.
- STREAM:
  - oPixel = mem[rbank][byte] bits[7-2*pix : 6-2*pix], combinational read of the register array.
  - While oPixelValid && !iPixelReady, oPixel and all counters hold.
  - On handshake: pix++; at pix==3, pix<=0 and byte++. No bubble between bytes (1 pixel/cycle sustained).
  - Handshake of byte==LINE_BYTES-1, pix==3:
    - bank_full[rbank]<=0, rbank toggles, oLineDone pulse.
    - oLineCount increments, wrapping LINES_PER_FRAME-1 -> 0 with an oFrameDone pulse.
    - If the other bank is already full: stay in STREAM, valid remains 1, no gap.
    - Else: go to IDLE, valid<=0.

Simultaneous events:
- A read-side clear and a write-side fill of different banks in the same cycle both take effect.
- A write to a bank being cleared in the same cycle is still dropped, because full is sampled at cycle start.
- oOverflow clears only on reset.

Decomposition:
- Shared package holds GB_LINE_PIXELS=160, GB_LINE_BYTES=40, GB_VISIBLE_LINES=144, the 2-bit pixel type, and FSM state encodings IDLE/STREAM.
- One natural sub-module: fb_line_bank, one 40x8 register array with synchronous write and combinational read, instantiated twice.
- Control, counters and FSM stay in the parent.

Test Plan:
- Single line: write bytes 0..39 with byte k = k; iPixelReady=1 -> oPixelValid rises 1 cycle after the addr-39 write; 160 pixels follow; for byte 1 the pixels are 0,0,0,1 in order; oLineDone on pixel 159; oLineCount 0->1.
- Back-to-back: fill bank1 while bank0 streams, ready=1 -> 320 contiguous valid cycles with no gap; two oLineDone pulses.
- Backpressure: ready toggling 1,0,1,0 -> oPixel stable while ready=0; pixel sequence identical to the ready=1 run; line takes 320 cycles.
- Overflow: ready=0, write three full lines -> first two accepted, third dropped; oOverflow=1 from the first dropped write; after release, streamed data matches lines 1 and 2 only.
- Out-of-range and boundary: write addr=40 and addr=255 -> no state change; stream 144 lines -> oFrameDone coincident with the 144th oLineDone; oLineCount wraps to 0.
- Reset mid-line: assert iReset at pixel 50 -> next cycle oPixelValid=0, all counters 0, bank_full=0; a fresh line then streams correctly from pixel 0.

Source files
------------

// File: rtl/fb_line_buffer_pkg.sv
// Shared constants, pixel type and read-FSM encodings for the framebuffer line buffer.
package fb_line_buffer_pkg;

  localparam int GB_LINE_PIXELS   = 160;
  localparam int GB_LINE_BYTES    = 40;
  localparam int GB_VISIBLE_LINES = 144;

  typedef logic [1:0] pixel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

  // Pixel 0 lives in the top bit pair of each byte.
  function automatic pixel_t unpack_pixel(input logic [7:0] b, input logic [1:0] idx);
    pixel_t p;
    case (idx)
      2'd0:    p = b[7:6];
      2'd1:    p = b[5:4];
      2'd2:    p = b[3:2];
      default: p = b[1:0];
    endcase
    return p;
  endfunction

endpackage

// File: rtl/fb_line_bank.sv
// One scanline of packed pixels: synchronous write, combinational read.
// Zero read latency; no flow control of its own, the parent decides when to write.
module fb_line_bank
  import fb_line_buffer_pkg::*;
#(
  parameter int DEPTH = GB_LINE_BYTES,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fb_line_buffer.sv
// Ping-pong scanline store between the GPU framebuffer port and a valid/ready pixel stream.
// First pixel one cycle after a bank fills; ready low freezes the stream, writes to a full bank are dropped and flagged.
module fb_line_buffer
  import fb_line_buffer_pkg::*;
#(
  parameter int LINE_BYTES      = GB_LINE_BYTES,
  parameter int LINES_PER_FRAME = GB_VISIBLE_LINES
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iFrameBufferWe,
  input  logic [7:0] iFrameBufferData,
  input  logic [7:0] iFrameBufferAddr,
  output logic [1:0] oPixel,
  output logic       oPixelValid,
  input  logic       iPixelReady,
  output logic       oLineDone,
  output logic       oFrameDone,
  output logic [7:0] oLineCount,
  output logic       oOverflow
);

  localparam int             AW        = $clog2(LINE_BYTES);
  localparam logic [AW-1:0]  LAST_BYTE = AW'(LINE_BYTES - 1);
  localparam logic [7:0]     LAST_LINE = 8'(LINES_PER_FRAME - 1);

  rd_state_t     state_q, state_d;
  logic          wbank_q, rbank_q, rbank_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic [AW-1:0] byte_q, byte_d;
  logic [1:0]    pix_q, pix_d;
  logic [7:0]    line_q, line_d;
  logic          overflow_q;
  logic          rd_release;
  logic          line_done, frame_done;
  logic [7:0]    bank_rd [2];

  logic wr_in_range, wr_accept, wr_close;

  assign wr_in_range = iFrameBufferWe && (iFrameBufferAddr < 8'(LINE_BYTES));
  assign wr_accept   = wr_in_range && !bank_full_q[wbank_q];
  assign wr_close    = wr_accept && (iFrameBufferAddr == 8'(LINE_BYTES - 1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_line_bank #(
      .DEPTH (LINE_BYTES),
      .AW    (AW)
    ) u_bank (
      .clk     (iClock),
      .we      (wr_accept && (wbank_q == 1'(b))),
      .wr_addr (iFrameBufferAddr[AW-1:0]),
      .wr_data (iFrameBufferData),
      .rd_addr (byte_q),
      .rd_data (bank_rd[b])
    );
  end

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    pix_d      = pix_q;
    line_d     = line_q;
    rbank_d    = rbank_q;
    rd_release = 1'b0;
    line_done  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bank_full_q[rbank_q]) begin
          state_d = STREAM;
          byte_d  = '0;
          pix_d   = '0;
        end
      end
      STREAM: begin
        if (iPixelReady) begin
          pix_d = pix_q + 2'd1;
          if (pix_q == 2'd3) begin
            byte_d = byte_q + 1'b1;
            if (byte_q == LAST_BYTE) begin
              byte_d     = '0;
              rd_release = 1'b1;
              line_done  = 1'b1;
              rbank_d    = ~rbank_q;
              if (line_q == LAST_LINE) begin
                line_d     = '0;
                frame_done = 1'b1;
              end else begin
                line_d = line_q + 8'd1;
              end
              // Chain straight into the other bank when it is already waiting.
              if (!bank_full_q[~rbank_q]) state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Release and fill always target different banks: a fill needs the bank empty at cycle start.
  always_comb begin
    bank_full_d = bank_full_q;
    if (rd_release) bank_full_d[rbank_q] = 1'b0;
    if (wr_close)   bank_full_d[wbank_q] = 1'b1;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q     <= IDLE;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      bank_full_q <= 2'b00;
      byte_q      <= '0;
      pix_q       <= '0;
      line_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rbank_q     <= rbank_d;
      bank_full_q <= bank_full_d;
      byte_q      <= byte_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      if (wr_close) wbank_q <= ~wbank_q;
      if (wr_in_range && bank_full_q[wbank_q]) overflow_q <= 1'b1;
    end
  end

  assign oPixelValid = (state_q == STREAM);
  assign oPixel      = oPixelValid ? unpack_pixel(bank_rd[rbank_q], pix_q) : 2'b00;
  assign oLineDone   = line_done;
  assign oFrameDone  = frame_done;
  assign oLineCount  = line_q;
  assign oOverflow   = overflow_q;

endmodule

// File: tb/tb_fb_line_buffer.sv
// Directed bench for fb_line_buffer: single line, back-to-back, backpressure, overflow, reset, frame wrap.
module tb_fb_line_buffer;

  logic       iClock;
  logic       iReset;
  logic       iFrameBufferWe;
  logic [7:0] iFrameBufferData;
  logic [7:0] iFrameBufferAddr;
  logic [1:0] oPixel;
  logic       oPixelValid;
  logic       iPixelReady;
  logic       oLineDone;
  logic       oFrameDone;
  logic [7:0] oLineCount;
  logic       oOverflow;

  fb_line_buffer dut (
    .iClock           (iClock),
    .iReset           (iReset),
    .iFrameBufferWe   (iFrameBufferWe),
    .iFrameBufferData (iFrameBufferData),
    .iFrameBufferAddr (iFrameBufferAddr),
    .oPixel           (oPixel),
    .oPixelValid      (oPixelValid),
    .iPixelReady      (iPixelReady),
    .oLineDone        (oLineDone),
    .oFrameDone       (oFrameDone),
    .oLineCount       (oLineCount),
    .oOverflow        (oOverflow)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] got_q [$];
  int         ld_at [$];
  int         fd_at [$];
  int         gap_cycles, stable_err, valid_cycles, first_vld;

  int         fd_lines, fd_line_idx, fd_pos, tot_mism, tot_ld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  function automatic logic [7:0] line_byte(input int sel, input int k);
    int v;
    v = (sel == 0) ? k : (k * 37 + sel * 91 + 5);
    return v[7:0];
  endfunction

  function automatic logic [1:0] exp_pix(input int sel, input int n);
    logic [7:0] b;
    b = line_byte(sel, n / 4);
    return 2'((b >> (6 - 2 * (n % 4))) & 8'h03);
  endfunction

  function automatic int mism(input int sel, input int off);
    int m = 0;
    for (int n = 0; n < 160; n++)
      if (off + n >= got_q.size() || got_q[off + n] !== exp_pix(sel, n)) m++;
    return m;
  endfunction

  task automatic wr(input int addr, input int data);
    iFrameBufferWe   = 1'b1;
    iFrameBufferAddr = addr[7:0];
    iFrameBufferData = data[7:0];
    tick();
    iFrameBufferWe   = 1'b0;
  endtask

  task automatic write_line(input int sel);
    for (int k = 0; k < 40; k++) wr(k, int'(line_byte(sel, k)));
  endtask

  // mode 0: ready always high; mode 1: ready 0,1,0,1... starting at the first valid cycle
  task automatic stream(input int mode, input int npix);
    int         cyc;
    logic       hold;
    logic [1:0] held;
    got_q.delete();
    ld_at.delete();
    fd_at.delete();
    gap_cycles   = 0;
    stable_err   = 0;
    valid_cycles = 0;
    first_vld    = -1;
    hold         = 1'b0;
    held         = 2'b00;
    cyc          = 0;
    while (got_q.size() < npix && cyc < npix * 3 + 50) begin
      if (first_vld < 0 && oPixelValid) first_vld = cyc;
      if (mode == 0) iPixelReady = 1'b1;
      else           iPixelReady = (first_vld >= 0) && (((cyc - first_vld) % 2) == 1);
      #1;
      if (oPixelValid) begin
        valid_cycles++;
        if (hold && oPixel !== held) stable_err++;
        if (iPixelReady) begin
          if (oLineDone)  ld_at.push_back(got_q.size());
          if (oFrameDone) fd_at.push_back(got_q.size());
          got_q.push_back(oPixel);
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          held = oPixel;
        end
      end else if (got_q.size() > 0) begin
        gap_cycles++;
      end
      cyc++;
      tick();
    end
    check("stream_len", got_q.size(), npix);
  endtask

  initial begin
    iReset           = 1'b1;
    iFrameBufferWe   = 1'b0;
    iFrameBufferData = 8'h00;
    iFrameBufferAddr = 8'h00;
    iPixelReady      = 1'b1;
    repeat (3) tick();
    check("rst_valid", oPixelValid, 0);
    check("rst_pixel", oPixel, 0);
    check("rst_linedone", oLineDone, 0);
    check("rst_framedone", oFrameDone, 0);
    check("rst_linecount", oLineCount, 0);
    check("rst_overflow", oOverflow, 0);
    iReset = 1'b0;
    tick();

    // Single line, byte k = k
    write_line(0);
    check("t1_valid_at_full", oPixelValid, 0);
    check("t1_count_before", oLineCount, 0);
    stream(0, 160);
    check("t1_first_valid_cyc", first_vld, 1);
    check("t1_data", mism(0, 0), 0);
    check("t1_byte1_pixels", {got_q[4], got_q[5], got_q[6], got_q[7]}, 8'h01);
    check("t1_valid_cycles", valid_cycles, 160);
    check("t1_linedone_n", ld_at.size(), 1);
    check("t1_linedone_pos", (ld_at.size() > 0) ? ld_at[0] : -1, 159);
    check("t1_no_framedone", fd_at.size(), 0);
    check("t1_count_after", oLineCount, 1);

    // Back-to-back: second bank fills while the first streams
    write_line(2);
    fork
      stream(0, 320);
      write_line(3);
    join
    check("b2b_data0", mism(2, 0), 0);
    check("b2b_data1", mism(3, 160), 0);
    check("b2b_valid_cycles", valid_cycles, 320);
    check("b2b_gaps", gap_cycles, 0);
    check("b2b_linedone_n", ld_at.size(), 2);
    check("b2b_linedone_0", (ld_at.size() > 0) ? ld_at[0] : -1, 159);
    check("b2b_linedone_1", (ld_at.size() > 1) ? ld_at[1] : -1, 319);
    check("b2b_count", oLineCount, 3);

    // Backpressure with alternating ready
    write_line(0);
    stream(1, 160);
    check("bp_data", mism(0, 0), 0);
    check("bp_stable", stable_err, 0);
    check("bp_valid_cycles", valid_cycles, 320);
    check("bp_linedone_pos", (ld_at.size() > 0) ? ld_at[0] : -1, 159);
    check("bp_count", oLineCount, 4);

    // Overflow: consumer stalled, three lines offered
    iPixelReady = 1'b0;
    write_line(4);
    write_line(5);
    check("ovf_two_lines_ok", oOverflow, 0);
    wr(40, 8'hAA);
    wr(255, 8'h55);
    check("oor_no_overflow", oOverflow, 0);
    check("oor_count", oLineCount, 4);
    wr(0, int'(line_byte(6, 0)));
    check("ovf_first_drop", oOverflow, 1);
    for (int k = 1; k < 40; k++) wr(k, int'(line_byte(6, k)));
    check("ovf_sticky", oOverflow, 1);
    stream(0, 320);
    check("ovf_data_line1", mism(4, 0), 0);
    check("ovf_data_line2", mism(5, 160), 0);
    check("ovf_linedone_n", ld_at.size(), 2);
    check("ovf_no_third", oPixelValid, 0);
    repeat (3) tick();
    check("ovf_no_third_late", oPixelValid, 0);
    check("ovf_count", oLineCount, 6);
    check("ovf_still_set", oOverflow, 1);

    // Reset at pixel 50 of a line
    write_line(7);
    stream(0, 50);
    check("mid_valid_pre", oPixelValid, 1);
    iReset = 1'b1;
    tick();
    check("mid_rst_valid", oPixelValid, 0);
    check("mid_rst_pixel", oPixel, 0);
    check("mid_rst_count", oLineCount, 0);
    check("mid_rst_overflow", oOverflow, 0);
    check("mid_rst_linedone", oLineDone, 0);
    iReset = 1'b0;
    repeat (3) tick();
    check("mid_banks_empty", oPixelValid, 0);
    write_line(8);
    stream(0, 160);
    check("mid_fresh_data", mism(8, 0), 0);
    check("mid_fresh_linedone", (ld_at.size() > 0) ? ld_at[0] : -1, 159);
    check("mid_fresh_count", oLineCount, 1);

    // Remaining 143 lines of the frame
    fd_lines    = 0;
    fd_line_idx = -1;
    fd_pos      = -1;
    tot_mism    = 0;
    tot_ld      = 0;
    for (int i = 0; i < 143; i++) begin
      write_line(10 + i);
      stream(0, 160);
      tot_mism += mism(10 + i, 0);
      tot_ld   += ld_at.size();
      if (fd_at.size() > 0) begin
        fd_lines   += fd_at.size();
        fd_line_idx = i;
        fd_pos      = fd_at[0];
      end
    end
    check("frm_data", tot_mism, 0);
    check("frm_linedone_total", tot_ld, 143);
    check("frm_framedone_n", fd_lines, 1);
    check("frm_framedone_line", fd_line_idx, 142);
    check("frm_framedone_pos", fd_pos, 159);
    check("frm_count_wrap", oLineCount, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
